// File: rtl/timed_setting_sched.sv
// Timed settings-bus scheduler: queues (time, addr, data) commands in order and
// issues each as a one-cycle settings write once vita_time reaches its timestamp.
module timed_setting_sched #(
  parameter int DEPTH     = 4,
  parameter int DROP_LATE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [63:0]              cmd_time,
  input  logic                     cmd_now,
  input  logic [7:0]               cmd_addr,
  input  logic [31:0]              cmd_data,
  input  logic                     flush,
  input  logic [63:0]              vita_time,
  output logic                     set_stb,
  output logic [7:0]               set_addr,
  output logic [31:0]              set_data,
  output logic                     late,
  output logic [15:0]              late_count,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);

  localparam int   AW   = $clog2(DEPTH);
  localparam int   CW   = AW + 1;
  localparam logic DROP = (DROP_LATE != 0);

  typedef enum logic [1:0] {ST_EMPTY, ST_WAIT, ST_FIRE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] wr_ptr, rd_ptr;
  logic          head_new, head_new_n;
  logic          push, pop, fire, late_evt;
  logic          due, is_late;

  logic [63:0]   mem_time [0:DEPTH-1];
  logic          mem_now  [0:DEPTH-1];
  logic [7:0]    mem_addr [0:DEPTH-1];
  logic [31:0]   mem_data [0:DEPTH-1];

  logic [63:0]   head_time;
  logic          head_now;
  logic [7:0]    head_addr;
  logic [31:0]   head_data;

  assign count     = wr_ptr - rd_ptr;
  assign busy      = (count != '0);
  assign cmd_ready = rst_n & (count != CW'(DEPTH)) & ~flush;
  assign push      = cmd_valid & cmd_ready;

  assign head_time = mem_time[rd_ptr[AW-1:0]];
  assign head_now  = mem_now[rd_ptr[AW-1:0]];
  assign head_addr = mem_addr[rd_ptr[AW-1:0]];
  assign head_data = mem_data[rd_ptr[AW-1:0]];

  assign due     = head_now | (head_time <= vita_time);
  assign is_late = head_new & ~head_now & (head_time < vita_time);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_time[wr_ptr[AW-1:0]] <= cmd_time;
      mem_now[wr_ptr[AW-1:0]]  <= cmd_now;
      mem_addr[wr_ptr[AW-1:0]] <= cmd_addr;
      mem_data[wr_ptr[AW-1:0]] <= cmd_data;
    end
  end

  // Lateness is judged only on a head's first WAIT evaluation, so a head that
  // simply waited until it became due is never reported late.
  always_comb begin
    state_n  = state;
    pop      = 1'b0;
    fire     = 1'b0;
    late_evt = 1'b0;
    case (state)
      ST_EMPTY: if (count != '0) state_n = ST_WAIT;
      ST_WAIT: begin
        late_evt = is_late;
        if (is_late && DROP) begin
          pop = 1'b1;
          if (count == CW'(1) && !push) state_n = ST_EMPTY;
        end else if (due) begin
          pop     = 1'b1;
          fire    = 1'b1;
          state_n = ST_FIRE;
        end
      end
      ST_FIRE:  state_n = (count != '0) ? ST_WAIT : ST_EMPTY;
      default:  state_n = ST_EMPTY;
    endcase
    if (flush) begin
      state_n  = ST_EMPTY;
      pop      = 1'b0;
      fire     = 1'b0;
      late_evt = 1'b0;
    end
  end

  assign head_new_n = pop | (state != ST_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      head_new   <= 1'b1;
      set_stb    <= 1'b0;
      set_addr   <= '0;
      set_data   <= '0;
      late       <= 1'b0;
      late_count <= '0;
    end else begin
      state    <= state_n;
      head_new <= head_new_n;
      set_stb  <= fire;
      late     <= late_evt;
      if (fire) begin
        set_addr <= head_addr;
        set_data <= head_data;
      end
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        late_count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + CW'(1);
        if (pop)  rd_ptr <= rd_ptr + CW'(1);
        if (late_evt && late_count != 16'hFFFF) late_count <= late_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_timed_setting_sched.sv
// Bench for timed_setting_sched: one instance issues late commands, the other
// drops them; both share the same stimulus.
module tb_timed_setting_sched;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic [63:0] cmd_time;
  logic        cmd_now;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        flush;
  logic [63:0] vita_time;

  logic        cmd_ready0, set_stb0, late0, busy0;
  logic [7:0]  set_addr0;
  logic [31:0] set_data0;
  logic [15:0] late_count0;
  logic [2:0]  count0;

  logic        cmd_ready1, set_stb1, late1, busy1;
  logic [7:0]  set_addr1;
  logic [31:0] set_data1;
  logic [15:0] late_count1;
  logic [2:0]  count1;

  int   checks = 0;
  int   errors = 0;
  logic time_run = 1'b0;

  typedef struct {
    logic [63:0] start;
    logic        step;
    logic [63:0] t;
    logic        now;
    logic [7:0]  addr;
    logic [31:0] data;
    int          jump_cyc;
    logic [63:0] jump_to;
    int          exp_stb0;
    int          exp_stb1;
    int          exp_late;
    int          exp_cyc;
    int          exp_count0;
  } vec_t;

  vec_t vecs [12];

  int          r_stb0, r_stb1, r_late0, r_late1, r_cyc, r_lcyc;
  logic [7:0]  r_addr;
  logic [31:0] r_data;

  timed_setting_sched #(.DEPTH(4), .DROP_LATE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
    .cmd_time(cmd_time), .cmd_now(cmd_now), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .flush(flush), .vita_time(vita_time), .set_stb(set_stb0), .set_addr(set_addr0),
    .set_data(set_data0), .late(late0), .late_count(late_count0), .count(count0),
    .busy(busy0)
  );

  timed_setting_sched #(.DEPTH(4), .DROP_LATE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
    .cmd_time(cmd_time), .cmd_now(cmd_now), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .flush(flush), .vita_time(vita_time), .set_stb(set_stb1), .set_addr(set_addr1),
    .set_data(set_data1), .late(late1), .late_count(late_count1), .count(count1),
    .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (time_run) vita_time = vita_time + 64'd1;
  endtask

  task automatic doFlush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    time_run  = 1'b0;
    cmd_valid = 1'b0;
    doFlush();
    vita_time = v.start;
    time_run  = v.step;
    cmd_valid = 1'b1;
    cmd_time  = v.t;
    cmd_now   = v.now;
    cmd_addr  = v.addr;
    cmd_data  = v.data;
    tick();
    cmd_valid = 1'b0;
    cmd_now   = 1'b0;
    r_stb0 = 0; r_stb1 = 0; r_late0 = 0; r_late1 = 0; r_cyc = 0; r_lcyc = 0;
    r_addr = '0; r_data = '0;
    for (int k = 1; k <= 40; k++) begin
      if (v.jump_cyc == k) vita_time = v.jump_to;
      tick();
      if (set_stb0) begin r_stb0++; r_cyc = k; r_addr = set_addr0; r_data = set_data0; end
      if (late0) begin r_late0++; r_lcyc = k; end
      if (set_stb1) r_stb1++;
      if (late1) r_late1++;
    end
    tag = $sformatf("v%0d", idx);
    checkOutput({tag, "_stb_issue"}, r_stb0, v.exp_stb0);
    checkOutput({tag, "_stb_drop"}, r_stb1, v.exp_stb1);
    checkOutput({tag, "_late_issue"}, r_late0, v.exp_late);
    checkOutput({tag, "_late_drop"}, r_late1, v.exp_late);
    checkOutput({tag, "_lcnt_issue"}, late_count0, v.exp_late);
    checkOutput({tag, "_lcnt_drop"}, late_count1, v.exp_late);
    checkOutput({tag, "_count"}, count0, v.exp_count0);
    if (v.exp_stb0 != 0) begin
      checkOutput({tag, "_stb_cycle"}, r_cyc, v.exp_cyc);
      checkOutput({tag, "_addr"}, r_addr, v.addr);
      checkOutput({tag, "_data"}, r_data, v.data);
    end
    if (v.exp_late != 0) checkOutput({tag, "_late_cycle"}, r_lcyc, v.exp_cyc);
  endtask

  initial begin
    int          n, acc, hits;
    logic        pre;
    logic [7:0]  ord_addr [8];
    int          ord_cyc  [8];

    // start, step, time, now, addr, data, jump_cyc, jump_to, stb0, stb1, late, cyc, count0
    vecs[0]  = '{64'd100, 1'b1, 64'd120, 1'b0, 8'h05, 32'hDEADBEEF, 0, 64'd0, 1, 1, 0, 20, 0};
    vecs[1]  = '{64'd500, 1'b0, 64'd500, 1'b0, 8'h12, 32'h00000012, 0, 64'd0, 1, 1, 0, 2, 0};
    vecs[2]  = '{64'd1000, 1'b0, 64'd900, 1'b0, 8'h21, 32'h0BAD0900, 0, 64'd0, 1, 0, 1, 2, 0};
    vecs[3]  = '{64'd1000, 1'b0, 64'd0, 1'b1, 8'h33, 32'hC0DE0003, 0, 64'd0, 1, 1, 0, 2, 0};
    vecs[4]  = '{64'd1000, 1'b0, 64'd999, 1'b0, 8'h44, 32'h44440999, 0, 64'd0, 1, 0, 1, 2, 0};
    vecs[5]  = '{64'd300, 1'b1, 64'd302, 1'b0, 8'h55, 32'h55550302, 0, 64'd0, 1, 1, 0, 2, 0};
    vecs[6]  = '{64'd300, 1'b1, 64'd301, 1'b0, 8'h66, 32'h66660301, 0, 64'd0, 1, 0, 1, 2, 0};
    vecs[7]  = '{64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 8'h77,
                 32'h7777FFF8, 0, 64'd0, 1, 1, 0, 8, 0};
    vecs[8]  = '{64'h0000_0001_0000_0000, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 8'h88,
                 32'h88888888, 0, 64'd0, 0, 0, 0, 0, 1};
    vecs[9]  = '{64'd10, 1'b1, 64'd25, 1'b1, 8'h99, 32'h99990025, 0, 64'd0, 1, 1, 0, 2, 0};
    vecs[10] = '{64'd10, 1'b0, 64'd5000, 1'b0, 8'hA1, 32'hA1A15000, 1, 64'd6000, 1, 0, 1, 2, 0};
    vecs[11] = '{64'd10, 1'b0, 64'd5000, 1'b0, 8'hB2, 32'hB2B25000, 4, 64'd6000, 1, 1, 0, 4, 0};

    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_now   = 1'b1;
    cmd_time  = 64'd7;
    cmd_addr  = 8'hFF;
    cmd_data  = 32'hFFFFFFFF;
    flush     = 1'b0;
    vita_time = 64'd123;
    repeat (3) tick();
    checkOutput("rst_stb", set_stb0, 0);
    checkOutput("rst_addr", set_addr0, 0);
    checkOutput("rst_data", set_data0, 0);
    checkOutput("rst_late", late0, 0);
    checkOutput("rst_lcnt", late_count0, 0);
    checkOutput("rst_count", count0, 0);
    checkOutput("rst_busy", busy0, 0);
    checkOutput("rst_ready", cmd_ready0, 0);
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    #1;
    checkOutput("rel_ready", cmd_ready0, 1);
    tick();
    checkOutput("rel_count", count0, 0);
    checkOutput("rel_stb", set_stb0, 0);

    // Reset in the middle of a write with a second command still queued
    cmd_valid = 1'b1;
    cmd_now   = 1'b1;
    cmd_addr  = 8'h11;
    tick();
    cmd_addr  = 8'h22;
    tick();
    cmd_valid = 1'b0;
    tick();
    checkOutput("mid_stb", set_stb0, 1);
    checkOutput("mid_addr", set_addr0, 8'h11);
    checkOutput("mid_count", count0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_stb", set_stb0, 0);
    checkOutput("mid_rst_count", count0, 0);
    checkOutput("mid_rst_ready", cmd_ready0, 0);
    checkOutput("mid_rst_addr", set_addr0, 0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    cmd_now = 1'b0;
    #1;
    checkOutput("mid_rel_ready", cmd_ready0, 1);

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

    // Fill to DEPTH, then the fifth command waits for the first pop
    time_run  = 1'b0;
    cmd_valid = 1'b0;
    doFlush();
    vita_time = 64'd50;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd_time  = 64'd200 + 64'(i);
      cmd_addr  = 8'(i + 1);
      cmd_data  = 32'hA0000000 + 32'(i);
      tick();
    end
    cmd_time = 64'd204;
    cmd_addr = 8'd5;
    cmd_data = 32'hA0000004;
    tick();
    checkOutput("full_count", count0, 4);
    checkOutput("full_ready", cmd_ready0, 0);
    checkOutput("full_busy", busy0, 1);
    for (int i = 0; i < 8; i++) begin ord_addr[i] = '0; ord_cyc[i] = 0; end
    vita_time = 64'd198;
    time_run  = 1'b1;
    n   = 0;
    acc = 0;
    for (int k = 1; k <= 60; k++) begin
      pre = cmd_valid & cmd_ready0;
      tick();
      if (pre) begin acc = k; cmd_valid = 1'b0; end
      if (set_stb0) begin
        if (n < 8) begin ord_addr[n] = set_addr0; ord_cyc[n] = k; end
        n++;
      end
    end
    time_run = 1'b0;
    checkOutput("ord_n", n, 5);
    checkOutput("ord_first_cyc", ord_cyc[0], 3);
    checkOutput("ord_accept_after_pop", (acc > ord_cyc[0]) ? 1 : 0, 1);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("ord_addr%0d", i), ord_addr[i], i + 1);
      if (i > 0) checkOutput($sformatf("ord_gap%0d", i), ord_cyc[i] - ord_cyc[i-1], 2);
    end
    checkOutput("ord_lcnt", late_count0, 4);

    // Flush collides with a push while future commands are queued
    cmd_valid = 1'b0;
    doFlush();
    vita_time = 64'd10;
    cmd_valid = 1'b1;
    cmd_time  = 64'd1;
    cmd_addr  = 8'h30;
    tick();
    cmd_valid = 1'b0;
    repeat (4) tick();
    checkOutput("fl_pre_lcnt0", late_count0, 1);
    checkOutput("fl_pre_lcnt1", late_count1, 1);
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1;
      cmd_time  = 64'd5000 + 64'(i);
      cmd_addr  = 8'h40 + 8'(i);
      tick();
    end
    checkOutput("fl_pre_count0", count0, 3);
    checkOutput("fl_pre_count1", count1, 3);
    flush    = 1'b1;
    cmd_now  = 1'b1;
    cmd_addr = 8'hAA;
    #1;
    checkOutput("fl_ready", cmd_ready0, 0);
    tick();
    flush     = 1'b0;
    cmd_valid = 1'b0;
    cmd_now   = 1'b0;
    checkOutput("fl_count0", count0, 0);
    checkOutput("fl_count1", count1, 0);
    checkOutput("fl_lcnt0", late_count0, 0);
    checkOutput("fl_lcnt1", late_count1, 0);
    checkOutput("fl_busy", busy0, 0);
    vita_time = 64'd9000;
    hits = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (set_stb0 || set_stb1 || late0 || late1) hits++;
    end
    checkOutput("fl_no_activity", hits, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timed_setting_sched.md
# timed_setting_sched

Timed command scheduler for the settings bus that configures the 64-bit VITA time base and other timed registers. Software or the control path queues `(time, addr, data)` commands. The block holds them in a small in-order FIFO and issues each as a one-cycle settings-bus write once `vita_time` reaches the command's timestamp. Late commands are flagged and counted. It sits between the command source and the `set_stb/set_addr/set_data` bus that feeds `setting_reg` instances, including the time base's own registers.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, 2..16.
- `DROP_LATE`, default 0: 1 = late commands are discarded; 0 = late commands are issued immediately.
- `clk`  in  1  single clock; all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted on a posedge where `cmd_valid & cmd_ready`.
- `cmd_time`  in  64  issue time, same format as `vita_time`.
- `cmd_now`  in  1  ignore `cmd_time` and issue as soon as the command reaches the head; never flagged late.
- `cmd_addr`  in  8  settings address.
- `cmd_data`  in  32  settings data.
- `flush`  in  1  synchronous clear of all queued commands.
- `vita_time`  in  64  current time from the time base.
- `set_stb`  out  1  settings write strobe, registered.
- `set_addr`  out  8  settings address, registered.
- `set_data`  out  32  settings data, registered.
- `late`  out  1  one-cycle pulse: head command was found late.
- `late_count`  out  16  late commands since reset or flush; saturates at 16'hFFFF.
- `count`  out  log2(DEPTH)+1  current FIFO occupancy.
- `busy`  out  1  `count != 0`.

## Operation
- FIFO: in-order, DEPTH entries. Each entry holds 64+1+8+32 bits. Read/write pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
- `cmd_ready = rst_n & (count != DEPTH) & ~flush`. This is combinational.
- A push and a pop in the same cycle are both honoured, and `count` is unchanged.
- The FSM has three states: EMPTY, WAIT, FIRE.
  - EMPTY: `count == 0`. Moves to WAIT on the edge after `count` becomes nonzero.
  - WAIT: evaluates the head entry every cycle. "Due" means `cmd_now` or `cmd_time <= vita_time` (unsigned 64-bit compare). "Late" means `~cmd_now & (cmd_time < vita_time)` on the first WAIT cycle that sees this head.
    - Due and not (late & DROP_LATE): register `set_stb=1` with the head's addr/data, pop the head, go to FIRE.
    - Late & DROP_LATE: pop the head, `set_stb` stays 0, stay in WAIT (or go to EMPTY if the queue is now empty).
    - Any late head: pulse `late`, increment `late_count`.
    - Not due: hold state.
  - FIRE: lasts exactly one cycle, `set_stb=1`. Then WAIT if `count != 0`, else EMPTY. Consequence: at most one write every 2 cycles.
- "First WAIT cycle for a head" is tracked by a `head_new` flag. It is set on entry to WAIT and on every pop, and cleared after the first evaluation. A head that was on time but became due later is never late.
- `flush`: at the next edge, pointers and `count` go to 0 and the FSM goes to EMPTY. `late_count` clears; `set_stb`, `late` deassert. Flush has priority over push, pop, and FIRE. A FIRE already registered and showing on `set_stb` in the flush cycle completes; no new write is started.
- `set_addr`/`set_data` hold their last value when `set_stb` is 0.

## Timing
- Async reset (`rst_n` low) sets, immediately:
  - `set_stb=0`, `set_addr=0`, `set_data=0`;
  - `late=0`, `late_count=0`, `count=0`, `busy=0`;
  - `cmd_ready=0`, FSM=EMPTY.
- Reset release: `cmd_ready=1` in the first cycle after release.
- Reset mid-operation: all queued commands are lost. A `set_stb` in progress drops immediately.
- Latency, command due at acceptance: accepted at edge N → WAIT from edge N+1 → `set_stb` high in the cycle after edge N+2 → low after edge N+3.
- Latency, timed command: `set_stb` rises on the first edge after the WAIT cycle in which `vita_time == cmd_time`. It is therefore high while `vita_time == cmd_time+1` when `vita_time` increments every cycle.
- `late` is coincident with the edge that would register `set_stb`. With DROP_LATE=0, `late` and `set_stb` rise on the same edge.
- `vita_time` jumps (time-base preset or MIMO sync) are tolerated. Only `<=`/`<` against the current value matters; the block never wraps time.

## Test plan
- Reset/idle: hold `rst_n`=0 with traffic on the inputs → all outputs 0; after release, `cmd_ready=1`, `count=0`, no `set_stb`.
- Timed issue: `vita_time` counts from 100; push `{time=120, addr=8'h05, data=32'hDEADBEEF}` → exactly one `set_stb` pulse, registered in the cycle with `vita_time==121`, `set_addr=05`, `set_data=DEADBEEF`; `late=0`.
- Full/ordering: DEPTH=4; push 5 commands with times 200,201,202,203,204 at `vita_time=50` → `cmd_ready=0` after the 4th; the 5th is accepted after the first pop; the 5 strobes come out in push order, at least 2 cycles apart.
- Late handling: `vita_time=1000`, push `time=900`.
  - DROP_LATE=0 → `late` pulse, `set_stb` issued, `late_count=1`.
  - DROP_LATE=1 → `late` pulse, no `set_stb`.
  - `cmd_now=1` with `time=0` → issued, no `late`.
- Flush collision: queue 3 future commands; assert `flush` with `cmd_valid=1` in the same cycle → next cycle `count=0`, `late_count=0`, no `set_stb` afterwards, pushed command dropped.
- Time jump: head `time=5000`, `vita_time` jumps 10→6000 → `late=1`, `late_count=1`, and the command is issued or dropped per DROP_LATE.
